fetch_queue: RTL and testbench

- Parametrised decoupling buffer between program-memory fetch and the IF/DEC boundary.
- Holds {PC, instruction} pairs in a circular FIFO, so fetch keeps running while decode stalls.
- Replaces the single-entry hold/flush path with configurable depth.
- Uses an epoch tag to drop fetch responses that were already in flight when a branch redirect occurred.

---
 rtl/fetch_queue.sv | 120 ++++++++++++
 tb/tb_fetch_queue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode: holds {PC, instruction}
// pairs and discards fetch responses tagged with an epoch older than the last redirect.
module fetch_queue #(
    parameter int XLEN    = 32,
    parameter int ILEN    = 32,
    parameter int DEPTH   = 4,
    parameter int EPOCH_W = 2
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     flush,
    input  logic                     push_valid,
    input  logic [EPOCH_W-1:0]       push_epoch,
    input  logic [XLEN-1:0]          push_PC,
    input  logic [ILEN-1:0]          push_inst,
    output logic                     push_ready,
    output logic                     pop_valid,
    input  logic                     pop_ready,
    output logic [XLEN-1:0]          pop_PC,
    output logic [ILEN-1:0]          pop_inst,
    output logic [EPOCH_W-1:0]       epoch,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stale_drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]    pc_mem_r   [DEPTH];
    logic [ILEN-1:0]    inst_mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r, wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic [EPOCH_W-1:0] epoch_r, epoch_nxt_s;
    logic               full_s, empty_s, push_acc_s, pop_acc_s, epoch_match_s;

    // Full/empty come from the occupancy counter; pointers alone cannot tell them apart.
    assign full_s        = (count_r == CNT_W'(DEPTH));
    assign empty_s       = (count_r == {CNT_W{1'b0}});
    assign epoch_match_s = (push_epoch == epoch_r);
    assign push_ready    = ~full_s;
    assign pop_valid     = ~empty_s & ~flush;
    assign push_acc_s    = push_valid & ~full_s & epoch_match_s & ~flush;
    assign pop_acc_s     = pop_valid & pop_ready;
    assign stale_drop    = push_valid & (~epoch_match_s | flush);
    assign epoch         = epoch_r;
    assign count         = count_r;

    // Head entry presented to decode; zero when nothing is queued.
    always_comb begin
        pop_PC   = {XLEN{1'b0}};
        pop_inst = {ILEN{1'b0}};
        if (!empty_s) begin
            pop_PC   = pc_mem_r[rd_ptr_r];
            pop_inst = inst_mem_r[rd_ptr_r];
        end else begin
            pop_PC   = {XLEN{1'b0}};
            pop_inst = {ILEN{1'b0}};
        end
    end

    // Next-state for pointers, occupancy and epoch; a redirect overrides push and pop.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        epoch_nxt_s  = epoch_r;
        if (flush) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
            epoch_nxt_s  = epoch_r + EPOCH_W'(1);
        end else begin
            if (push_acc_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_acc_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            case ({push_acc_s, pop_acc_s})
                2'b10:   count_nxt_s = count_r + CNT_W'(1);
                2'b01:   count_nxt_s = count_r - CNT_W'(1);
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            epoch_r  <= {EPOCH_W{1'b0}};
        end else begin
            rd_ptr_r <= rd_ptr_nxt_s;
            wr_ptr_r <= wr_ptr_nxt_s;
            count_r  <= count_nxt_s;
            epoch_r  <= epoch_nxt_s;
        end
    end

    // Entry storage, written only by an accepted push.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= {XLEN{1'b0}};
                inst_mem_r[i] <= {ILEN{1'b0}};
            end
        end else if (push_acc_s) begin
            pc_mem_r[wr_ptr_r]   <= push_PC;
            inst_mem_r[wr_ptr_r] <= push_inst;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the buffer.
module tb_fetch_queue;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int DEPTH   = 4;
    localparam int EPOCH_W = 2;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    logic               Clock;
    logic               nReset;
    logic               flush;
    logic               push_valid;
    logic [EPOCH_W-1:0] push_epoch;
    logic [XLEN-1:0]    push_PC;
    logic [ILEN-1:0]    push_inst;
    logic               push_ready;
    logic               pop_valid;
    logic               pop_ready;
    logic [XLEN-1:0]    pop_PC;
    logic [ILEN-1:0]    pop_inst;
    logic [EPOCH_W-1:0] epoch;
    logic [CNT_W-1:0]   count;
    logic               stale_drop;

    fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .EPOCH_W(EPOCH_W)) dut (
        .Clock(Clock), .nReset(nReset), .flush(flush),
        .push_valid(push_valid), .push_epoch(push_epoch), .push_PC(push_PC),
        .push_inst(push_inst), .push_ready(push_ready), .pop_valid(pop_valid),
        .pop_ready(pop_ready), .pop_PC(pop_PC), .pop_inst(pop_inst),
        .epoch(epoch), .count(count), .stale_drop(stale_drop)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } entry_t;

    entry_t mq[$];
    int     m_epoch;
    int     total;
    int     bad;
    bit     chk_en;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of one clock edge, using the inputs present before the edge.
    function automatic void model_edge();
        int  sz;
        bit  push_ok;
        bit  pop_ok;
        entry_t e;
        sz = mq.size();
        if (flush) begin
            mq.delete();
            m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
        end else begin
            push_ok = push_valid && (int'(push_epoch) == m_epoch) && (sz < DEPTH);
            pop_ok  = pop_ready && (sz > 0);
            if (pop_ok) void'(mq.pop_front());
            if (push_ok) begin
                e.pc = push_PC;
                e.inst = push_inst;
                mq.push_back(e);
            end
        end
    endfunction

    // Compare process: all outputs against the model, mid-cycle.
    always @(negedge Clock) begin
        if (chk_en) begin
            check("count", 64'(count), 64'(mq.size()));
            check("push_ready", 64'(push_ready), 64'(mq.size() < DEPTH));
            check("pop_valid", 64'(pop_valid), 64'((mq.size() != 0) && !flush));
            check("pop_PC", 64'(pop_PC), (mq.size() != 0) ? 64'(mq[0].pc) : 64'd0);
            check("pop_inst", 64'(pop_inst), (mq.size() != 0) ? 64'(mq[0].inst) : 64'd0);
            check("epoch", 64'(epoch), 64'(m_epoch));
            check("stale_drop", 64'(stale_drop),
                  64'(push_valid && ((int'(push_epoch) != m_epoch) || flush)));
        end
    end

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
    endtask

    task automatic set_push(input bit v, input int ep, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] inst);
        push_valid = v;
        push_epoch = EPOCH_W'(ep);
        push_PC    = pc;
        push_inst  = inst;
    endtask

    logic [XLEN-1:0] pcs3 [3];
    logic [ILEN-1:0] insts3 [3];
    int              ep_seq [4];

    initial begin
        total = 0; bad = 0; chk_en = 1'b0; m_epoch = 0;
        nReset = 1'b0; flush = 1'b0; pop_ready = 1'b0;
        set_push(1'b0, 0, 32'h0, 32'h0);
        pcs3   = '{32'h00, 32'h04, 32'h08};
        insts3 = '{32'h00000013, 32'h00100093, 32'h00200113};
        ep_seq = '{2, 3, 0, 1};
        #12;
        check("rst_count", 64'(count), 64'd0);
        check("rst_push_ready", 64'(push_ready), 64'd1);
        check("rst_pop_valid", 64'(pop_valid), 64'd0);
        check("rst_pop_PC", 64'(pop_PC), 64'd0);
        check("rst_epoch", 64'(epoch), 64'd0);
        nReset = 1'b1;
        chk_en = 1'b1;

        // three pushes popped in order, one cycle after each push
        pop_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, 0, pcs3[i], insts3[i]);
            tick();
            check("s1_pop_PC", 64'(pop_PC), 64'(pcs3[i]));
            check("s1_pop_inst", 64'(pop_inst), 64'(insts3[i]));
        end
        set_push(1'b0, 0, 32'h0, 32'h0);
        tick();
        check("s1_empty", 64'(count), 64'd0);

        // fill to DEPTH with pop held, fifth push waits
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_push(1'b1, 0, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
            tick();
        end
        check("s2_full_count", 64'(count), 64'd4);
        check("s2_push_ready", 64'(push_ready), 64'd0);
        check("s2_head", 64'(pop_PC), 64'h100);
        pop_ready = 1'b1;
        tick();
        check("s3_full_pop_count", 64'(count), 64'd3);
        check("s3_next_head", 64'(pop_PC), 64'h104);
        tick();
        check("s2_fifth_in", 64'(count), 64'd3);
        set_push(1'b0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check("s2_drained", 64'(count), 64'd0);

        // flush with two entries queued and an in-flight epoch-0 push
        pop_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_push(1'b1, 0, 32'h200 + 32'(4 * i), 32'h11);
            tick();
        end
        flush = 1'b1;
        set_push(1'b1, 0, 32'h300, 32'h22);
        #1;
        check("s4_flush_pop_valid", 64'(pop_valid), 64'd0);
        check("s4_flush_stale", 64'(stale_drop), 64'd1);
        tick();
        flush = 1'b0;
        check("s4_count0", 64'(count), 64'd0);
        check("s4_epoch1", 64'(epoch), 64'd1);
        set_push(1'b1, 0, 32'h304, 32'h33);
        #1;
        check("s4_old_epoch_stale", 64'(stale_drop), 64'd1);
        tick();
        set_push(1'b1, 1, 32'h40, 32'h44);
        #1;
        check("s4_new_epoch_ok", 64'(stale_drop), 64'd0);
        tick();
        check("s4_count1", 64'(count), 64'd1);
        check("s4_pc40", 64'(pop_PC), 64'h40);
        set_push(1'b0, 1, 32'h0, 32'h0);
        pop_ready = 1'b1;
        tick();

        // 20 push/pop pairs across several pointer wraps
        for (int i = 0; i < 20; i++) begin
            set_push(1'b1, 1, 32'h1000 + 32'(4 * i), 32'(i * 7));
            tick();
            check("s5_wrap_order", 64'(pop_PC), 64'(32'h1000 + 32'(4 * i)));
        end
        set_push(1'b0, 1, 32'h0, 32'h0);
        tick();

        // consecutive flushes each advance the epoch
        flush = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("s5_epoch_seq", 64'(epoch), 64'(ep_seq[i]));
        end
        flush = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            flush     = ($urandom_range(0, 19) == 0);
            pop_ready = ($urandom_range(0, 2) != 0);
            set_push($urandom_range(0, 3) != 0,
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : m_epoch,
                     $urandom, $urandom);
            tick();
        end

        // asynchronous reset with three entries held
        flush = 1'b1;
        set_push(1'b0, 0, 32'h0, 32'h0);
        tick();
        flush = 1'b0;
        pop_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_push(1'b1, m_epoch, 32'h500 + 32'(4 * i), 32'h55);
            tick();
        end
        set_push(1'b0, m_epoch, 32'h0, 32'h0);
        check("s6_pre_count", 64'(count), 64'd3);
        chk_en = 1'b0;
        #1;
        nReset = 1'b0;
        #1;
        check("s6_async_count", 64'(count), 64'd0);
        check("s6_async_pop_valid", 64'(pop_valid), 64'd0);
        check("s6_async_pop_PC", 64'(pop_PC), 64'd0);
        check("s6_async_pop_inst", 64'(pop_inst), 64'd0);
        check("s6_async_epoch", 64'(epoch), 64'd0);
        mq.delete();
        m_epoch = 0;
        @(negedge Clock);
        #1;
        nReset = 1'b1;
        chk_en = 1'b1;
        check("s6_push_ready", 64'(push_ready), 64'd1);
        check("s6_epoch0", 64'(epoch), 64'd0);
        set_push(1'b1, 0, 32'h600, 32'h66);
        tick();
        set_push(1'b0, 0, 32'h0, 32'h0);
        check("s6_after_push", 64'(pop_PC), 64'h600);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
